// File: rtl/cw305_instr_feeder.sv
// Host-register-fed instruction FIFO that hands words one at a time to the OBI write bridge,
// and latches OBI read responses and a completed-transfer count for host readback.
module cw305_instr_feeder #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  reg_addr,
  input  logic        reg_we,
  input  logic        reg_re,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        inst_valid,
  output logic [31:0] instruction,
  input  logic        busy,
  input  logic        OBI_rvalid,
  input  logic [31:0] OBI_rdata
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW:0]   DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  // state     | meaning
  // IDLE      | no transfer; pops the head when run=1 and the FIFO is non-empty
  // ISSUE     | inst_valid held until the bridge raises busy
  // WAIT_DONE | waiting for busy to fall, then the transfer is counted
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t        state, state_nxt;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [3:0]    count4;
  logic          run, overflow, timeout, rdata_valid;
  logic [31:0]   rdata_reg, done_cnt, rd_mux;
  logic [TW-1:0] tmr;
  logic          pop, done, engine_active, tmr_inc;
  logic          wr_instr, wr_ctrl, flush, clr, push_ok, rd_rdata, full, empty;

  assign wr_instr = reg_we && (reg_addr == 3'd0);
  assign wr_ctrl  = reg_we && (reg_addr == 3'd1);
  assign flush    = wr_ctrl && reg_wdata[1];
  assign clr      = wr_ctrl && reg_wdata[2];
  assign rd_rdata = reg_re && (reg_addr == 3'd3);
  assign full     = (count == DEPTH);
  assign empty    = (count == '0);
  assign count4   = 4'(count);
  // a full FIFO still takes a write when the head leaves in the same cycle
  assign push_ok  = wr_instr && (!full || pop);
  assign tmr_inc  = engine_active && (tmr != TMAX);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE:      if (run && !empty) begin pop = 1'b1; state_nxt = ISSUE; end
      ISSUE:     if (busy) state_nxt = WAIT_DONE;
      WAIT_DONE: if (!busy) begin done = 1'b1; state_nxt = IDLE; end
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    inst_valid    = (state == ISSUE);
    engine_active = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= reg_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      instruction <= '0;
    end else begin
      if (pop) instruction <= mem[rd_ptr];
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run         <= 1'b0;
      overflow    <= 1'b0;
      timeout     <= 1'b0;
      rdata_valid <= 1'b0;
      rdata_reg   <= '0;
      done_cnt    <= '0;
      tmr         <= '0;
    end else begin
      if (wr_ctrl) run <= reg_wdata[0];
      if (wr_instr && !push_ok) overflow <= 1'b1;
      else if (clr)             overflow <= 1'b0;
      if (OBI_rvalid) begin
        rdata_reg   <= OBI_rdata;
        rdata_valid <= 1'b1;
      end else if (rd_rdata || clr) begin
        rdata_valid <= 1'b0;
      end
      if (done) done_cnt <= done_cnt + 32'd1;
      if (pop)          tmr <= '0;
      else if (tmr_inc) tmr <= tmr + 1'b1;
      if (tmr_inc && (tmr == TLAST)) timeout <= 1'b1;
      else if (clr)                  timeout <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      3'd2: rd_mux = {20'd0, count4, 2'b00, timeout, rdata_valid, overflow,
                      engine_active, full, empty};
      3'd3: rd_mux = rdata_reg;
      3'd4: rd_mux = done_cnt;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      reg_rdata <= '0;
    else if (reg_re) reg_rdata <= rd_mux;
  end

endmodule
